proc_result_bcd_capture: RTL and testbench
==========================================

Name: proc_result_bcd_capture

Overview:
- Captures the 16-bit result the multicycle processor publishes on its Done pulse.
- Converts it iteratively to packed BCD using shift-add-3 (double dabble), one bit per clock.
- Presents stable decimal digits plus a display-enable level to the seven-segment display stage downstream.
- Holds the last converted value between results and buffers one result that arrives mid-conversion.

Parameters:
- DATA_W, 16, width of the processor result (unsigned).
- DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_W - 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- PROC_done  in  1  single-cycle pulse: PROC_result is valid this cycle.
- PROC_result  in  DATA_W  unsigned processor result.
- BCD_out  out  4*DIGITS  packed BCD, digit 0 (units) in [3:0].
- DISP_done  out  1  level: BCD_out holds a valid converted result (display enable).
- result_valid  out  1  one-cycle pulse when BCD_out is updated.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE, BCD_out=0, DISP_done=0, result_valid=0, busy=0, pending flag=0, iteration count=0. Reset mid-conversion aborts it; no result_valid follows.
- States:
  - IDLE: on PROC_done=1, load the shift register with PROC_result, clear the BCD accumulator, set count=0, go to CONVERT.
  - CONVERT: busy=1. Each cycle, any accumulator digit >=5 gets +3 first; then {acc, shreg} shifts left 1.
- Completion:
  - On the cycle where count==DATA_W-1, the post-shift accumulator is written straight into BCD_out.
  - On that same edge: DISP_done<=1 and result_valid<=1 for exactly one cycle.
- Latency: PROC_done sampled at edge 0 -> BCD_out updated at edge DATA_W (16); result_valid high in the following cycle.
- BCD_out changes only at completion edges and never shows a partially converted value.
- DISP_done stays 1 from the first completion until reset; it does not drop during later conversions.
- PROC_done while in CONVERT: the value goes into a single-entry pending register and the pending flag is set. A further PROC_done overwrites the pending value (newest wins).
- At a completion edge:
  - Pending set: load the pending value, count=0, stay in CONVERT.
  - Pending set and PROC_done=1 on the same edge: load the pending value; the new value becomes the pending value (flag stays set).
  - No pending but PROC_done=1: load the new value directly, stay in CONVERT.
  - Neither: go to IDLE, busy=0.
- Arithmetic:
  - Accumulator width is 4*DIGITS.
  - Add-3 is applied per 4-bit digit and never carries between digits.
  - No overflow is possible for legal parameters.
  - Input is unsigned; no sign handling.
- PROC_done is ignored during reset. PROC_done held high for several cycles is treated as repeated pulses (pending rules apply).

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, CONVERT);
  - default DATA_W/DIGITS constants;
  - the all-ones "segment off" constant used by the display stage.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
1. Hold Resetn=0, then release -> BCD_out=20'h00000, DISP_done=0, busy=0, result_valid=0; no activity without PROC_done.
2. PROC_result=13, PROC_done pulse at cycle 0 -> busy=1 for 16 cycles; BCD_out=20'h00013 after edge 16; result_valid pulses once; DISP_done=1.
3. PROC_result=65535, then PROC_result=0 after idle -> BCD_out=20'h65535, then 20'h00000 with DISP_done still 1.
4. PROC_done with 1234 at cycle 0, 4321 at cycle 5, 999 at cycle 8:
   - BCD_out=20'h01234 at edge 16;
   - 20'h00999 at edge 32;
   - 4321 never appears;
   - exactly two result_valid pulses.
5. PROC_done with 500 at cycle 0, 77 exactly at completion edge 16 -> BCD_out=20'h00500 at edge 16, 20'h00077 at edge 32, busy continuous.
6. PROC_done with 42, Resetn pulsed low at cycle 8 -> all outputs 0 immediately; no result_valid; IDLE after release; next PROC_done converts normally.

Source files
------------

// File: rtl/proc_result_bcd_capture_pkg.sv
// Shared definitions for the processor-result BCD capture block.
// Holds the FSM state encoding, default widths and the display-stage blanking constant.
// Imported by the capture top and its digit-adjust cell.
package proc_result_bcd_capture_pkg;

  // Conversion FSM states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  // Default result width and digit count (10^5 > 2^16 - 1)
  localparam int DATA_W_DEF = 16;
  localparam int DIGITS_DEF = 5;

  // Active-low seven-segment pattern with every segment off, used by the display stage
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/proc_result_bcd_capture_bcd_digit_adj.sv
// Purpose : double-dabble digit correction, adds 3 to a BCD digit that is 5 or more.
// Latency : combinational.
// Ports   : digit_in (4-bit BCD digit) -> digit_out (corrected digit, no carry out).
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Inputs never exceed 9, so the sum stays within 4 bits and never carries
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = 4'(digit_in + 4'd3);
    end
  end

endmodule

// File: rtl/proc_result_bcd_capture.sv
// Purpose : captures the processor result on PROC_done and converts it to packed BCD,
//           one bit per clock (shift-add-3), holding the last value for the display stage.
// Latency : PROC_done sampled at edge 0 -> BCD_out updated at edge DATA_W, result_valid
//           high the following cycle. A result arriving mid-conversion waits in a
//           single-entry pending register (newest wins); no backpressure to the processor.
// Ports   : Clock, Resetn (async active-low), PROC_done/PROC_result (input pulse + data),
//           BCD_out (digit 0 in [3:0]), DISP_done (display enable level),
//           result_valid (update pulse), busy (conversion in progress).
module proc_result_bcd_capture
  import proc_result_bcd_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  PROC_done,
  input  logic [DATA_W-1:0]     PROC_result,
  output logic [4*DIGITS-1:0]   BCD_out,
  output logic                  DISP_done,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   pend_dat;
  logic                pend_vld;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic [DATA_W-1:0]   shreg_shift;
  logic                last_bit;

  // Per-digit add-3 correction; digits are independent, no inter-digit carry
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_in  (acc[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  // Correct first, then shift {acc, shreg} left by one
  always_comb begin
    acc_shift   = {acc_adj[ACC_W-2:0], shreg[DATA_W-1]};
    shreg_shift = {shreg[DATA_W-2:0], 1'b0};
    last_bit    = (cnt == CNT_LAST);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      acc          <= '0;
      cnt          <= '0;
      pend_dat     <= '0;
      pend_vld     <= 1'b0;
      BCD_out      <= '0;
      DISP_done    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (PROC_done) begin
            shreg <= PROC_result;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_CONVERT;
          end
        end

        ST_CONVERT: begin
          acc   <= acc_shift;
          shreg <= shreg_shift;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // Final shift goes straight to the output so no partial value is ever shown
            BCD_out      <= acc_shift;
            DISP_done    <= 1'b1;
            result_valid <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
            if (pend_vld) begin
              // Older buffered result goes first; a same-edge arrival refills the buffer
              shreg    <= pend_dat;
              pend_vld <= PROC_done;
              if (PROC_done) begin
                pend_dat <= PROC_result;
              end
            end else if (PROC_done) begin
              shreg <= PROC_result;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (PROC_done) begin
            pend_dat <= PROC_result;
            pend_vld <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_result_bcd_capture.sv
// Directed bench for proc_result_bcd_capture: reset, single conversions, pending
// buffer behaviour (newest wins, same-edge arrival) and mid-conversion reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_proc_result_bcd_capture;

  logic        Clock;
  logic        Resetn;
  logic        PROC_done;
  logic [15:0] PROC_result;
  logic [19:0] BCD_out;
  logic        DISP_done;
  logic        result_valid;
  logic        busy;

  int checks;
  int errors;

  // Monitor counters (written only by the monitor process)
  int rv_cnt;
  int seen_4321;
  int busy_drops;
  logic mon_busy;

  proc_result_bcd_capture #(.DATA_W(16), .DIGITS(5)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .PROC_done    (PROC_done),
    .PROC_result  (PROC_result),
    .BCD_out      (BCD_out),
    .DISP_done    (DISP_done),
    .result_valid (result_valid),
    .busy         (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    rv_cnt     = 0;
    seen_4321  = 0;
    busy_drops = 0;
  end

  always @(negedge Clock) begin
    if (result_valid) rv_cnt = rv_cnt + 1;
    if (BCD_out == 20'h04321) seen_4321 = seen_4321 + 1;
    if (mon_busy && !busy) busy_drops = busy_drops + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 unit after the last one
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Present val with PROC_done for exactly one sampling edge (edge 0)
  task automatic pulse(input logic [15:0] val);
    PROC_done   = 1'b1;
    PROC_result = val;
    wait_edges(1);
    PROC_done   = 1'b0;
    PROC_result = 16'h0;
  endtask

  int rv_base;
  int seen_base;

  initial begin
    checks      = 0;
    errors      = 0;
    mon_busy    = 1'b0;
    Resetn      = 1'b0;
    PROC_done   = 1'b0;
    PROC_result = 16'h0;

    // 1. reset state
    wait_edges(3);
    Resetn = 1'b1;
    check("rst_bcd",   32'(BCD_out), 32'h00000);
    check("rst_disp",  32'(DISP_done), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_rv",    32'(result_valid), 32'd0);
    wait_edges(5);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rv",   32'(rv_cnt), 32'd0);

    // 2. single conversion of 13
    rv_base = rv_cnt;
    pulse(16'd13);
    check("t2_busy_e0",  32'(busy), 32'd1);
    wait_edges(15);
    check("t2_bcd_e15",  32'(BCD_out), 32'h00000);
    check("t2_busy_e15", 32'(busy), 32'd1);
    check("t2_disp_e15", 32'(DISP_done), 32'd0);
    wait_edges(1);
    check("t2_bcd_e16",  32'(BCD_out), 32'h00013);
    check("t2_rv_e16",   32'(result_valid), 32'd1);
    check("t2_disp_e16", 32'(DISP_done), 32'd1);
    check("t2_busy_e16", 32'(busy), 32'd0);
    wait_edges(1);
    check("t2_rv_e17",   32'(result_valid), 32'd0);
    check("t2_rv_cnt",   32'(rv_cnt - rv_base), 32'd1);

    // 3. full-scale then zero
    pulse(16'd65535);
    wait_edges(16);
    check("t3_bcd_max", 32'(BCD_out), 32'h65535);
    wait_edges(2);
    pulse(16'd0);
    wait_edges(8);
    check("t3_hold_bcd",  32'(BCD_out), 32'h65535);
    check("t3_hold_disp", 32'(DISP_done), 32'd1);
    wait_edges(8);
    check("t3_bcd_zero", 32'(BCD_out), 32'h00000);
    check("t3_disp",     32'(DISP_done), 32'd1);
    wait_edges(2);

    // 4. pending overwrite: 1234 @0, 4321 @5, 999 @8
    rv_base   = rv_cnt;
    seen_base = seen_4321;
    pulse(16'd1234);
    wait_edges(4);
    pulse(16'd4321);
    wait_edges(2);
    pulse(16'd999);
    wait_edges(8);
    check("t4_bcd_e16", 32'(BCD_out), 32'h01234);
    check("t4_busy_e16", 32'(busy), 32'd1);
    wait_edges(15);
    check("t4_bcd_e31", 32'(BCD_out), 32'h01234);
    wait_edges(1);
    check("t4_bcd_e32", 32'(BCD_out), 32'h00999);
    check("t4_busy_e32", 32'(busy), 32'd0);
    wait_edges(3);
    check("t4_rv_cnt",  32'(rv_cnt - rv_base), 32'd2);
    check("t4_no_4321", 32'(seen_4321 - seen_base), 32'd0);

    // 5. new result exactly on the completion edge
    pulse(16'd500);
    mon_busy = 1'b1;
    wait_edges(15);
    pulse(16'd77);
    check("t5_bcd_e16", 32'(BCD_out), 32'h00500);
    check("t5_busy_e16", 32'(busy), 32'd1);
    wait_edges(15);
    mon_busy = 1'b0;
    wait_edges(1);
    check("t5_bcd_e32",  32'(BCD_out), 32'h00077);
    check("t5_busy_gap", 32'(busy_drops), 32'd0);
    wait_edges(2);

    // 6. reset in the middle of a conversion
    pulse(16'd42);
    wait_edges(7);
    Resetn = 1'b0;
    #1;
    check("t6_bcd",  32'(BCD_out), 32'h00000);
    check("t6_disp", 32'(DISP_done), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rv",   32'(result_valid), 32'd0);
    wait_edges(2);
    Resetn  = 1'b1;
    rv_base = rv_cnt;
    wait_edges(20);
    check("t6_no_rv",    32'(rv_cnt - rv_base), 32'd0);
    check("t6_idle",     32'(busy), 32'd0);
    check("t6_bcd_hold", 32'(BCD_out), 32'h00000);
    pulse(16'd2024);
    wait_edges(16);
    check("t6_bcd_next",  32'(BCD_out), 32'h02024);
    check("t6_disp_next", 32'(DISP_done), 32'd1);
    check("t6_rv_next",   32'(result_valid), 32'd1);
    wait_edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
